// File: rtl/alu4_pkg.sv
// Shared definitions for the alu4_ctrl sequencing stage.
//   - operation codes understood by the ALU and by this block
//   - FSM state encodings (IDLE, EXEC, HOLD)
//   - fixed op / data / result widths
//   - small helper to compute the zero flag
package alu4_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned RES_W  = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd4;
    localparam logic [OP_W-1:0] OP_LOAD = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    function automatic logic is_zero(input logic [DATA_W-1:0] d);
        return d == '0;
    endfunction

endpackage

// File: rtl/alu4_ctrl_fsm.sv
// Control FSM for alu4_ctrl: IDLE -> EXEC -> HOLD -> IDLE.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     upstream command present
//   out_ready    downstream accepts the held result
//   in_ready     block can accept a command (state decode, no path from out_ready)
//   out_valid    result is valid (state decode)
//   accept       command handshake completes on this edge
//   exec         datapath should capture the ALU result on this edge
module alu4_ctrl_fsm
    import alu4_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic accept,
    output logic exec
);

    logic [1:0] state_q;
    logic [1:0] state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_EXEC;
            ST_EXEC:                state_d = ST_HOLD;
            ST_HOLD: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_ready && in_valid;
    assign exec      = (state_q == ST_EXEC);

endmodule

// File: rtl/alu4_ctrl.sv
// alu4_ctrl: sequencing stage feeding a 4-bit combinational ALU.
// Accepts one command (op, operand) over valid/ready, drives the ALU from the
// accumulator and the latched operand, captures the 5-bit ALU result, updates
// the accumulator (and optionally carry/zero flags), and presents the result
// downstream over valid/ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     command handshake; op (3b), operand (4b)
//   alu_s/alu_a/alu_b     ALU select and operands (alu_a is the accumulator)
//   alu_y                 ALU 5-bit result (combinational from alu_s/a/b)
//   out_valid/out_ready   result handshake; result (5b)
//   acc                   accumulator
//   carry, zero           status flags of the last result
// Configuration:
//   ALU4_CTRL_FLAGS_EN    when defined, carry/zero are registered; otherwise tied to 0.
module alu4_ctrl
    import alu4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] operand,
    output logic [OP_W-1:0]   alu_s,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  result,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              zero
);

    logic accept;
    logic exec;

    logic [OP_W-1:0]   alu_s_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [RES_W-1:0]  result_q;
    logic [DATA_W-1:0] acc_q;
    logic [RES_W-1:0]  res_d;

    alu4_ctrl_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .accept    (accept),
        .exec      (exec)
    );

    // ALU select/operand change only on the accept edge so the ALU sees
    // stable inputs throughout EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_s_q <= '0;
            alu_b_q <= '0;
        end else if (accept) begin
            alu_s_q <= op;
            alu_b_q <= operand;
        end
    end

    // Load bypasses the ALU; its value was latched onto alu_b.
    always_comb begin
        res_d = alu_y;
        if (alu_s_q == OP_LOAD) begin
            res_d = {1'b0, alu_b_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            acc_q    <= '0;
        end else if (exec) begin
            result_q <= res_d;
            acc_q    <= res_d[DATA_W-1:0];
        end
    end

`ifdef ALU4_CTRL_FLAGS_EN
    logic carry_q;
    logic zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (exec) begin
            carry_q <= res_d[RES_W-1];
            zero_q  <= is_zero(res_d[DATA_W-1:0]);
        end
    end

    assign carry = carry_q;
    assign zero  = zero_q;
`else
    assign carry = 1'b0;
    assign zero  = 1'b0;
`endif

    assign alu_s  = alu_s_q;
    assign alu_a  = acc_q;
    assign alu_b  = alu_b_q;
    assign result = result_q;
    assign acc    = acc_q;

endmodule

// File: tb/tb_alu4_ctrl.sv
// Directed testbench for alu4_ctrl with a behavioural 4-bit ALU beside it.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu4_ctrl;

`ifdef ALU4_CTRL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] operand;
    logic [2:0] alu_s;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [4:0] alu_y;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] result;
    logic [3:0] acc;
    logic       carry;
    logic       zero;

    int n_vec = 0;
    int n_err = 0;

    alu4_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .alu_s     (alu_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .acc       (acc),
        .carry     (carry),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model; op 7 returns a junk value so a load that used it would show.
    always_comb begin
        alu_y = 5'h00;
        case (alu_s)
            3'd0:    alu_y = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1:    alu_y = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2:    alu_y = {1'b0, alu_a & alu_b};
            3'd4:    alu_y = {1'b0, alu_a | alu_b};
            3'd7:    alu_y = 5'h15;
            default: alu_y = 5'h00;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents a command for one accept edge; returns at the falling edge in EXEC.
    task automatic send(input logic [2:0] o, input logic [3:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        operand  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Runs a full command with out_ready high, checking EXEC and HOLD cycles.
    task automatic run_cmd(input string nm, input logic [2:0] o, input logic [3:0] d,
                           input logic [4:0] e_res, input logic e_c, input logic e_z);
        logic [3:0] acc_before;
        acc_before = acc;
        send(o, d);
        n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++;
            $display("FAIL %s exec_hs: in_ready=%b out_valid=%b want 0 0", nm, in_ready, out_valid); end
        n_vec++; if (alu_s !== o || alu_b !== d || alu_a !== acc_before) begin n_err++;
            $display("FAIL %s alu_in: s=%h a=%h b=%h want %h %h %h", nm, alu_s, alu_a, alu_b,
                     o, acc_before, d); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || result !== e_res) begin n_err++;
            $display("FAIL %s hold: out_valid=%b result=%h want 1 %h", nm, out_valid, result,
                     e_res); end
        n_vec++; if (acc !== e_res[3:0] || alu_a !== e_res[3:0]) begin n_err++;
            $display("FAIL %s acc: acc=%h alu_a=%h want %h", nm, acc, alu_a, e_res[3:0]); end
        n_vec++; if (carry !== (FLAGS & e_c) || zero !== (FLAGS & e_z)) begin n_err++;
            $display("FAIL %s flags: carry=%b zero=%b want %b %b", nm, carry, zero,
                     FLAGS & e_c, FLAGS & e_z); end
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++;
            $display("FAIL %s idle: in_ready=%b out_valid=%b want 1 0", nm, in_ready, out_valid); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; operand = 4'd0; out_ready = 1'b1;
        #12;
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
        n_vec++; if (alu_s !== 3'd0 || alu_a !== 4'd0 || alu_b !== 4'd0) begin n_err++;
            $display("FAIL reset_alu: s=%h a=%h b=%h want 0 0 0", alu_s, alu_a, alu_b); end
        n_vec++; if (result !== 5'd0 || acc !== 4'd0 || carry !== 1'b0 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_data: result=%h acc=%h c=%b z=%b want 0 0 0 0", result, acc,
                     carry, zero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        run_cmd("load9", 3'd7, 4'h9, 5'h09, 1'b0, 1'b0);
    endtask

    task automatic test_add_carry();
        run_cmd("add_c", 3'd0, 4'h8, 5'h11, 1'b1, 1'b0);
    endtask

    task automatic test_sub_borrow();
        run_cmd("load3", 3'd7, 4'h3, 5'h03, 1'b0, 1'b0);
        run_cmd("sub_b", 3'd1, 4'h5, 5'h1E, 1'b1, 1'b0);
    endtask

    task automatic test_logic();
        run_cmd("and", 3'd2, 4'h5, 5'h04, 1'b0, 1'b0);
        run_cmd("or", 3'd4, 4'h3, 5'h07, 1'b0, 1'b0);
        run_cmd("add_wrap", 3'd0, 4'h9, 5'h10, 1'b1, 1'b1);
    endtask

    task automatic test_unsupported();
        run_cmd("loadF", 3'd7, 4'hF, 5'h0F, 1'b0, 1'b0);
        run_cmd("op5", 3'd5, 4'h3, 5'h00, 1'b0, 1'b1);
        run_cmd("loadF2", 3'd7, 4'hF, 5'h0F, 1'b0, 1'b0);
        run_cmd("op3", 3'd3, 4'h1, 5'h00, 1'b0, 1'b1);
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        send(3'd7, 4'hA);
        @(negedge clk);
        // A competing command while HOLD is stalled must be ignored.
        in_valid = 1'b1; op = 3'd0; operand = 4'h5;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (out_valid !== 1'b1 || result !== 5'h0A || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: out_valid=%b result=%h in_ready=%b want 1 0a 0", i,
                         out_valid, result, in_ready); end
            n_vec++; if (alu_s !== 3'd7 || alu_b !== 4'hA) begin n_err++;
                $display("FAIL bp_alu[%0d]: s=%h b=%h want 7 a", i, alu_s, alu_b); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc !== 4'hA) begin n_err++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b acc=%h want 1 0 a", in_ready,
                     out_valid, acc); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || alu_s !== 3'd7) begin n_err++;
            $display("FAIL bp_no_queue: out_valid=%b alu_s=%h want 0 7", out_valid, alu_s); end
    endtask

    task automatic test_back_to_back();
        int seen = 0;
        int exp_r;
        run_cmd("load0", 3'd7, 4'h0, 5'h00, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; operand = 4'h1;
        // Accepts land on edges 1, 4, 7; results visible after edges 2, 5, 8.
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen++;
                exp_r = seen;
                n_vec++; if (result !== 5'(exp_r) || i != 3 * seen - 1) begin n_err++;
                    $display("FAIL b2b_result: cycle=%0d result=%h want %h at cycle %0d", i,
                             result, 5'(exp_r), 3 * seen - 1); end
            end
        end
        in_valid = 1'b0;
        n_vec++; if (seen != 3 || acc !== 4'h3 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL b2b_total: outputs=%0d acc=%h in_ready=%b want 3 3 1", seen, acc,
                     in_ready); end
    endtask

    task automatic test_mid_reset();
        int late_valid = 0;
        run_cmd("load6", 3'd7, 4'h6, 5'h06, 1'b0, 1'b0);
        send(3'd0, 4'h1);
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc !== 4'h0 || result !== 5'h0)
        begin n_err++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b acc=%h result=%h want 1 0 0 0",
                     in_ready, out_valid, acc, result); end
        n_vec++; if (alu_s !== 3'd0 || alu_b !== 4'd0 || carry !== 1'b0 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_alu: s=%h b=%h c=%b z=%b want 0 0 0 0", alu_s, alu_b, carry,
                     zero); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) late_valid++;
        end
        n_vec++; if (late_valid != 0 || acc !== 4'h0) begin n_err++;
            $display("FAIL mid_reset_after: out_valid cycles=%0d acc=%h want 0 0", late_valid,
                     acc); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add_carry();
        test_sub_borrow();
        test_logic();
        test_unsupported();
        test_back_pressure();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
